costas_loop_filter: RTL and testbench
=====================================

Name: costas_loop_filter

Overview:
- Second-order PI loop filter for the Costas carrier-recovery loop. Sits directly downstream of the phase detector.
- Consumes the 58-bit signed phase error stream and produces the NCO frequency control word as a signed offset around a programmable centre frequency.
- Also provides a lock indicator driven by a consecutive-sample counter.
- Pipelined, 3 cycles from input valid to output valid.

Parameters:
- PE_W, 58, phase error width (signed two's complement).
- ACC_W, 48, width of proportional term, integral term and integrator (signed).
- FW_W, 32, frequency word width.
- LOCK_CNT, 1024, consecutive in-threshold samples required to assert locked.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- phase_error  in  PE_W  signed phase error from the phase detector.
- pe_valid  in  1  qualifies phase_error for one cycle.
- loop_en  in  1  1 = loop closed; 0 = freeze integrator and output centre frequency.
- int_clr  in  1  synchronous integrator clear.
- kp_shift  in  6  proportional gain, 2^-kp_shift.
- ki_shift  in  6  integral gain, 2^-ki_shift.
- center_fw  in  FW_W  unsigned NCO centre frequency word.
- lock_thr  in  PE_W  unsigned lock threshold on |phase_error|.
- freq_word  out  FW_W  NCO frequency control word.
- fw_valid  out  1  one-cycle strobe, new freq_word.
- locked  out  1  carrier lock flag.

Behaviour:
- Reset (asynchronous, any time): all pipeline registers, integrator and lock counter cleared; freq_word=0, fw_valid=0, locked=0. Any in-flight samples are discarded.
- Stage 1: on pe_valid, register phase_error and compute |phase_error| as PE_W-bit unsigned. |-2^57| = 2^57 is representable with no overflow. Register v1.
- Stage 2, when v1=1:
  - p = sat_ACC(pe >>> kp_shift).
  - i_inc = sat_ACC(pe >>> ki_shift).
  - Shifts are arithmetic and round toward -inf, so -1>>>8 = -1.
  - sat_ACC clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Integrator update: integ <= sat_ACC(integ + i_inc), computed at ACC_W+1 bits before clamping.
  - The stage-2 output uses the updated integ value.
- Stage 3: offset = sat_FW(p + integ_new), clamped to [-2^31, 2^31-1]. freq_word <= center_fw + offset, modulo 2^FW_W (wrap is intended). fw_valid pulses 1 cycle.
- Latency: pe_valid at cycle N gives fw_valid at N+3. Throughput is 1 sample per clock. Back-to-back valid samples are all processed.
- Idle cycles: integrator and freq_word hold their values; fw_valid=0.
- loop_en=0: integrator holds and ignores i_inc. The offset is forced to 0, so freq_word=center_fw, and fw_valid still pulses per sample. The lock counter keeps running.
- int_clr=1: integrator <= 0 on that edge, with priority over an update in the same cycle. A sample in stage 2 in that cycle uses integ_new=0, so offset = sat_FW(p).
- center_fw, kp_shift and ki_shift are sampled at the stage where they are used. Changing them mid-stream affects subsequent samples only.
- Lock counter:
  - It counts per valid sample (stage 1 output). A sample with |pe| < lock_thr increments the counter, saturating at LOCK_CNT. A sample with |pe| >= lock_thr clears the counter to 0.
  - locked=1 when the counter equals LOCK_CNT, i.e. on the LOCK_CNT-th consecutive good sample.
  - locked drops to 0 in the cycle after the first bad sample registers.
  - lock_thr=0 means locked is never asserted.

Decomposition:
- Shared package costas_pkg:
  - width constants PE_W, ACC_W, FW_W;
  - a saturation function sat_signed(value, width);
  - LOCK_CNT default.
- One sub-module: costas_lock_detect, containing the magnitude compare and saturating counter and driving locked.
- The PI datapath stays in the top module.

Test Plan:
- Reset then idle: freq_word=0, fw_valid=0, locked=0. Assert sys_rst mid-stream: outputs return to 0 immediately and no stale fw_valid follows.
- PI step, with kp_shift=4, ki_shift=8, center_fw=0x1000_0000, loop_en=1, pe=4096 on consecutive cycles:
  - 1st fw_valid 3 cycles after the first pe_valid, freq_word=0x1000_0110 (256+16);
  - 2nd freq_word=0x1000_0120;
  - 3rd freq_word=0x1000_0130.
- Negative rounding, with pe=-1, kp_shift=8, ki_shift=8: p=-1, integ=-1, freq_word=center_fw-2.
- Saturation, with pe=2^57-1, kp_shift=ki_shift=0: integ clamps at 2^47-1 and offset clamps at 0x7FFF_FFFF. With center_fw=0x8000_0000, freq_word=0xFFFF_FFFF.
- Clear and freeze:
  - After 5 samples of the PI step, int_clr coincident with a sample gives freq_word=center_fw+256.
  - loop_en=0 gives freq_word=center_fw, and the integrator is unchanged when loop_en returns to 1.
- Lock, with LOCK_CNT=1024, lock_thr=100, pe=50:
  - locked rises exactly on the 1024th sample;
  - one pe=-100 sample drops locked;
  - a further 1023 good samples keep locked=0.

Source files
------------

// File: rtl/costas_pkg.sv
// Shared widths, lock-count default and the signed clamp helper for the
// Costas loop filter.
package costas_pkg;

  localparam int PE_W     = 58;
  localparam int ACC_W    = 48;
  localparam int FW_W     = 32;
  localparam int LOCK_CNT = 1024;

  // Clamp a sign-extended value into the range of a width-bit signed number.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage

// File: rtl/costas_lock_detect.sv
// Lock detector: counts consecutive samples with |pe| below threshold,
// saturating at LOCK_CNT; locked is high while the count sits at LOCK_CNT.
module costas_lock_detect #(
  parameter int PE_W     = 58,
  parameter int LOCK_CNT = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid,
  input  logic [PE_W-1:0] mag,
  input  logic [PE_W-1:0] thr,
  output logic            locked
);

  localparam int CNT_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_CNT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (valid) begin
      if (mag < thr) begin
        if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

  // A zero threshold can never be undercut, so the count stays at 0.
  assign locked = (cnt == CNT_MAX);

endmodule

// File: rtl/costas_loop_filter.sv
// Second-order PI loop filter: phase error in, NCO frequency word out,
// three register stages from pe_valid to fw_valid, plus a lock flag.
module costas_loop_filter #(
  parameter int PE_W     = costas_pkg::PE_W,
  parameter int ACC_W    = costas_pkg::ACC_W,
  parameter int FW_W     = costas_pkg::FW_W,
  parameter int LOCK_CNT = costas_pkg::LOCK_CNT
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic signed [PE_W-1:0] phase_error,
  input  logic                   pe_valid,
  input  logic                   loop_en,
  input  logic                   int_clr,
  input  logic [5:0]             kp_shift,
  input  logic [5:0]             ki_shift,
  input  logic [FW_W-1:0]        center_fw,
  input  logic [PE_W-1:0]        lock_thr,
  output logic [FW_W-1:0]        freq_word,
  output logic                   fw_valid,
  output logic                   locked
);

  import costas_pkg::*;

  // Stage 1: registered sample and its magnitude.
  logic signed [PE_W-1:0] pe_s1;
  logic [PE_W-1:0]        mag_s1;
  logic                   v1;
  logic [PE_W-1:0]        pe_mag;

  assign pe_mag = phase_error[PE_W-1] ? unsigned'(-phase_error) : unsigned'(phase_error);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pe_s1  <= '0;
      mag_s1 <= '0;
      v1     <= 1'b0;
    end else begin
      v1 <= pe_valid;
      if (pe_valid) begin
        pe_s1  <= phase_error;
        mag_s1 <= pe_mag;
      end
    end
  end

  // Stage 2: scaled terms and integrator update.
  logic signed [63:0]      pe_ext;
  logic signed [ACC_W-1:0] p_term;
  logic signed [ACC_W-1:0] i_inc;
  logic signed [ACC_W:0]   integ_sum;
  logic signed [ACC_W-1:0] integ_sat;
  logic signed [ACC_W-1:0] integ;
  logic signed [ACC_W-1:0] integ_next;

  assign pe_ext    = 64'(pe_s1);
  assign p_term    = ACC_W'(sat_signed(pe_ext >>> kp_shift, ACC_W));
  assign i_inc     = ACC_W'(sat_signed(pe_ext >>> ki_shift, ACC_W));
  assign integ_sum = (ACC_W+1)'(integ) + (ACC_W+1)'(i_inc);
  assign integ_sat = ACC_W'(sat_signed(64'(integ_sum), ACC_W));

  // Clear wins over an update; a frozen loop leaves the integrator alone.
  always_comb begin
    integ_next = integ;
    if (int_clr) begin
      integ_next = '0;
    end else if (v1 && loop_en) begin
      integ_next = integ_sat;
    end
  end

  logic signed [ACC_W-1:0] p_s2;
  logic signed [ACC_W-1:0] integ_s2;
  logic                    en_s2;
  logic                    v2;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      integ    <= '0;
      p_s2     <= '0;
      integ_s2 <= '0;
      en_s2    <= 1'b0;
      v2       <= 1'b0;
    end else begin
      integ <= integ_next;
      v2    <= v1;
      if (v1) begin
        p_s2     <= p_term;
        integ_s2 <= integ_next;
        en_s2    <= loop_en;
      end
    end
  end

  // Stage 3: clamp the PI sum to the frequency word range and add the centre.
  logic signed [ACC_W:0]  off_sum;
  logic signed [FW_W-1:0] offset;

  assign off_sum = (ACC_W+1)'(p_s2) + (ACC_W+1)'(integ_s2);
  assign offset  = en_s2 ? FW_W'(sat_signed(64'(off_sum), FW_W)) : '0;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      freq_word <= '0;
      fw_valid  <= 1'b0;
    end else begin
      fw_valid <= v2;
      if (v2) freq_word <= center_fw + unsigned'(offset);
    end
  end

  costas_lock_detect #(
    .PE_W     (PE_W),
    .LOCK_CNT (LOCK_CNT)
  ) u_lock (
    .clk    (sys_clk),
    .rst    (sys_rst),
    .valid  (v1),
    .mag    (mag_s1),
    .thr    (lock_thr),
    .locked (locked)
  );

endmodule

// File: tb/tb_costas_loop_filter.sv
// Bench for costas_loop_filter: directed test-plan steps followed by random
// streams, all checked against an arithmetic reference model.
module tb_costas_loop_filter;

  localparam int PE_W     = 58;
  localparam int ACC_W    = 48;
  localparam int FW_W     = 32;
  localparam int LOCK_CNT = 1024;

  logic                   sys_clk = 1'b0;
  logic                   sys_rst = 1'b1;
  logic signed [PE_W-1:0] phase_error = '0;
  logic                   pe_valid = 1'b0;
  logic                   loop_en = 1'b1;
  logic                   int_clr = 1'b0;
  logic [5:0]             kp_shift = '0;
  logic [5:0]             ki_shift = '0;
  logic [FW_W-1:0]        center_fw = '0;
  logic [PE_W-1:0]        lock_thr = '0;
  logic [FW_W-1:0]        freq_word;
  logic                   fw_valid;
  logic                   locked;

  costas_loop_filter dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .phase_error (phase_error),
    .pe_valid    (pe_valid),
    .loop_en     (loop_en),
    .int_clr     (int_clr),
    .kp_shift    (kp_shift),
    .ki_shift    (ki_shift),
    .center_fw   (center_fw),
    .lock_thr    (lock_thr),
    .freq_word   (freq_word),
    .fw_valid    (fw_valid),
    .locked      (locked)
  );

  // Clock / reset
  always #5 sys_clk = ~sys_clk;

  // Scoreboard state
  int              vectors = 0;
  int              miscompares = 0;
  int              cyc = 0;
  logic [FW_W-1:0] exp_q[$];
  int              due_q[$];
  int              lock_cyc_q[$];
  bit              lock_val_q[$];
  bit              exp_locked = 1'b0;
  bit              clr_next = 1'b0;
  longint          m_integ = 0;
  int              m_cnt = 0;

  function automatic longint floor_shift(longint v, int sh);
    longint d;
    longint q;
    d = longint'(1) << sh;
    q = v / d;
    if (v < 0 && q * d != v) q = q - 1;
    return q;
  endfunction

  function automatic longint clamp(longint v, int w);
    longint hi;
    longint lo;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: one accepted sample, in stream order.
  task automatic model_sample(longint pe, bit clr);
    longint p;
    longint inc;
    longint off;
    longint mag;
    logic [FW_W-1:0] fw;
    p   = clamp(floor_shift(pe, int'(kp_shift)), ACC_W);
    inc = clamp(floor_shift(pe, int'(ki_shift)), ACC_W);
    if (clr) m_integ = 0;
    else if (loop_en) m_integ = clamp(m_integ + inc, ACC_W);
    off = loop_en ? clamp(p + m_integ, FW_W) : 0;
    fw  = FW_W'(longint'(center_fw) + off);
    exp_q.push_back(fw);
    due_q.push_back(cyc + 3);
    mag = (pe < 0) ? -pe : pe;
    if (mag < longint'({6'b0, lock_thr})) m_cnt = (m_cnt < LOCK_CNT) ? m_cnt + 1 : LOCK_CNT;
    else m_cnt = 0;
    lock_cyc_q.push_back(cyc + 2);
    lock_val_q.push_back(m_cnt == LOCK_CNT);
  endtask

  // Driver: one clock cycle; checks outputs then drives this cycle's inputs.
  // clr asks for the integrator clear that coincides with this sample.
  task automatic step(bit v, longint pe, bit clr);
    @(negedge sys_clk);
    cyc++;
    while (lock_cyc_q.size() > 0 && lock_cyc_q[0] <= cyc) begin
      exp_locked = lock_val_q.pop_front();
      void'(lock_cyc_q.pop_front());
    end
    check("locked", 64'(locked), 64'(exp_locked));
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      check("fw_valid", 64'(fw_valid), 64'd1);
      check("freq_word", 64'(freq_word), 64'(exp_q.pop_front()));
      void'(due_q.pop_front());
    end else begin
      check("fw_valid", 64'(fw_valid), 64'd0);
    end
    int_clr     = clr_next;
    clr_next    = clr;
    pe_valid    = v;
    phase_error = PE_W'(pe);
    if (v) model_sample(pe, clr);
    else if (clr) m_integ = 0;
  endtask

  task automatic flush();
    for (int i = 0; i < 5; i++) step(1'b0, 0, 1'b0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    due_q.delete();
    lock_cyc_q.delete();
    lock_val_q.delete();
    exp_locked = 1'b0;
    clr_next   = 1'b0;
    m_integ    = 0;
    m_cnt      = 0;
  endtask

  function automatic longint rand_pe();
    logic signed [PE_W-1:0] t;
    case ($urandom_range(0, 3))
      0: return longint'($urandom_range(0, 10000)) - 5000;
      1: return longint'(int'($urandom));
      2: begin
        t = PE_W'({$urandom, $urandom});
        return longint'(t);
      end
      default: begin
        case ($urandom_range(0, 3))
          0: return -(longint'(1) << 57);
          1: return (longint'(1) << 57) - 1;
          2: return -1;
          default: return 0;
        endcase
      end
    endcase
  endfunction

  initial begin
    // Reset then idle
    #12;
    check("rst_freq_word", 64'(freq_word), 64'd0);
    check("rst_fw_valid", 64'(fw_valid), 64'd0);
    check("rst_locked", 64'(locked), 64'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    flush();

    // PI step
    kp_shift = 6'd4; ki_shift = 6'd8; center_fw = 32'h1000_0000;
    loop_en = 1'b1; lock_thr = PE_W'(100);
    for (int i = 0; i < 3; i++) step(1'b1, 4096, 1'b0);
    flush();
    check("pi_step_hold", 64'(freq_word), 64'h1000_0130);

    // Clear coincident with the sixth sample
    for (int i = 0; i < 2; i++) step(1'b1, 4096, 1'b0);
    step(1'b1, 4096, 1'b1);
    flush();
    check("int_clr", 64'(freq_word), 64'h1000_0100);

    // Freeze and release
    for (int i = 0; i < 2; i++) step(1'b1, 4096, 1'b0);
    flush();
    loop_en = 1'b0;
    for (int i = 0; i < 2; i++) step(1'b1, 4096, 1'b0);
    flush();
    check("loop_off", 64'(freq_word), 64'h1000_0000);
    loop_en = 1'b1;
    step(1'b1, 4096, 1'b0);
    flush();
    check("loop_back_on", 64'(freq_word), 64'h1000_0130);

    // Negative rounding toward -inf
    kp_shift = 6'd8; ki_shift = 6'd8;
    step(1'b0, 0, 1'b1);
    step(1'b1, -1, 1'b0);
    flush();
    check("neg_round", 64'(freq_word), 64'h0FFF_FFFE);

    // Saturation at both ends
    kp_shift = 6'd0; ki_shift = 6'd0; center_fw = 32'h8000_0000;
    for (int i = 0; i < 2; i++) step(1'b1, (longint'(1) << 57) - 1, 1'b0);
    flush();
    check("sat_pos", 64'(freq_word), 64'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) step(1'b1, -(longint'(1) << 57), 1'b0);
    flush();
    check("sat_neg", 64'(freq_word), 64'h0000_0000);

    // Reset while samples are in flight
    kp_shift = 6'd4; ki_shift = 6'd8; center_fw = 32'h1000_0000;
    for (int i = 0; i < 3; i++) step(1'b1, 4096, 1'b0);
    #2 sys_rst = 1'b1;
    pe_valid = 1'b0;
    int_clr  = 1'b0;
    model_reset();
    #1;
    check("midrst_freq_word", 64'(freq_word), 64'd0);
    check("midrst_fw_valid", 64'(fw_valid), 64'd0);
    check("midrst_locked", 64'(locked), 64'd0);
    step(1'b0, 0, 1'b0);
    sys_rst = 1'b0;
    flush();

    // Lock detector
    lock_thr = PE_W'(100);
    step(1'b1, 1000, 1'b0);
    for (int i = 0; i < LOCK_CNT - 1; i++) step(1'b1, 50, 1'b0);
    flush();
    check("lock_1023", 64'(locked), 64'd0);
    step(1'b1, 50, 1'b0);
    flush();
    check("lock_1024", 64'(locked), 64'd1);
    step(1'b1, -100, 1'b0);
    flush();
    check("lock_drop", 64'(locked), 64'd0);
    for (int i = 0; i < LOCK_CNT - 1; i++) step(1'b1, 50, 1'b0);
    flush();
    check("lock_regain_1023", 64'(locked), 64'd0);
    step(1'b1, 50, 1'b0);
    flush();
    check("lock_regain_1024", 64'(locked), 64'd1);

    // Random streams with random configuration between blocks
    for (int blk = 0; blk < 8; blk++) begin
      kp_shift  = 6'($urandom_range(0, 40));
      ki_shift  = 6'($urandom_range(0, 40));
      center_fw = $urandom;
      loop_en   = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 2))
        0: lock_thr = '0;
        1: lock_thr = PE_W'($urandom_range(1, 3000));
        default: lock_thr = PE_W'({$urandom, $urandom});
      endcase
      for (int i = 0; i < 80; i++)
        step($urandom_range(0, 3) != 0, rand_pe(), $urandom_range(0, 15) == 0);
      flush();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
